// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port in front of a
// word-organised little-endian RAM, with programmable wait states.
// Ports: clk, reset (async, active-low),
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err.
// Build option: MISALIGN_TRAP_EN faults misaligned half/word accesses.
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;

  logic [DATA_W-1:0]     r_mem [DEPTH];

  logic [DM_ADDRESS-3:0] w_idx;
  logic [1:0]            w_lane;
  logic [DATA_W-1:0]     w_word;
  logic [DATA_W-1:0]     w_shift;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_legal;
  logic                  w_misal;
  logic                  w_err;
  logic                  w_access;
  logic                  w_wr;
  logic [3:0]            w_be;
  logic [DATA_W-1:0]     w_wd;
  logic [DATA_W-1:0]     w_ld;

  assign w_idx   = r_addr[DM_ADDRESS-1:2];
  assign w_lane  = r_addr[1:0];
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_lane[1] ? w_word[31:16]
                             : w_word[15:0];

  always_comb begin
    w_legal = 1'b0;
    if (r_we)
      w_legal = r_f3 inside {3'b000, 3'b001, 3'b010};
    else
      w_legal = r_f3 inside {3'b000, 3'b001, 3'b010,
                             3'b100, 3'b101};
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    w_misal = 1'b0;
    if (r_f3[1:0] == 2'b01)
      w_misal = r_addr[0];
    else if (r_f3[1:0] == 2'b10)
      w_misal = (r_addr[1:0] != 2'b00);
  end
`else
  assign w_misal = 1'b0;
`endif

  assign w_err    = !w_legal || w_misal;
  assign w_access = (r_state == S_WAIT) &&
                    (r_cnt == 4'd0);
  assign w_wr     = w_access && r_we && !w_err;

  // Store data is replicated across lanes; the
  // byte enables pick which lanes land in RAM.
  always_comb begin
    w_be = 4'b0000;
    w_wd = r_wdata;
    case (r_f3[1:0])
      2'b00: begin
        w_be = 4'b0001 << w_lane;
        w_wd = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{r_wdata[15:0]}};
      end
      2'b10: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    w_ld = '0;
    case (r_f3)
      3'b000: w_ld = {{24{w_byte[7]}}, w_byte};
      3'b001: w_ld = {{16{w_half[15]}}, w_half};
      3'b010: w_ld = w_word;
      3'b100: w_ld = {24'd0, w_byte};
      3'b101: w_ld = {16'd0, w_half};
      default: w_ld = '0;
    endcase
  end

  // RAM is deliberately not reset; writes only
  // happen on the access edge of a live store.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_wr && w_be[i])
        r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_f3        <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_f3        <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= 4'(WAIT_STATES);
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata     <= (r_we || w_err) ? '0 : w_ld;
            r_err       <= w_err;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: loads, stores,
// back-pressure, reset abort and fault responses.
module tb_dmem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [8:0]  req_addr = 9'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_responder #(
    .DATA_W(32), .DM_ADDRESS(9), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_rdy_to"}, 32'd0, 32'd1);
  endtask

  task automatic xact(input string       tag,
                      input logic        we,
                      input logic [2:0]  f3,
                      input logic [8:0]  addr,
                      input logic [31:0] wd,
                      input logic [31:0] er,
                      input logic        ee,
                      input int          hold);
    exp_t e;
    int   lat = 0;
    bit   ok = 1'b0;
    logic [31:0] held;
    wait_ready(tag);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    q.push_back('{rdata: er, err: ee});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = 9'($urandom);
    req_wdata  = $urandom;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ok) check({tag, "_rsp_to"}, 32'd0, 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
    e = q.pop_front();
    check({tag, "_rdata"}, rsp_rdata, e.rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 2) begin
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 9'h040;
        req_wdata  = 32'hFFFF_FFFF;
      end
      if (i == 3) req_valid = 1'b0;
      check({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_d"}, rsp_rdata, held);
      check({tag, "_hold_rr"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_drop_v"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rel_rr"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rr", 32'(req_ready), 32'd0);
    check("rst_v", 32'(rsp_valid), 32'd0);
    check("rst_d", rsp_rdata, 32'd0);
    check("rst_e", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rise", 32'(req_ready), 32'd1);

    xact("sw10", 1, 3'b010, 9'h010, 32'hDEADBEEF, 0, 0, 0);
    xact("lw10", 0, 3'b010, 9'h010, 0, 32'hDEADBEEF, 0, 0);

    xact("sb11", 1, 3'b000, 9'h011, 32'h80, 0, 0, 0);
    xact("lb11", 0, 3'b000, 9'h011, 0, 32'hFFFFFF80, 0, 0);
    xact("lbu11", 0, 3'b100, 9'h011, 0, 32'h00000080, 0, 0);
    xact("lw10b", 0, 3'b010, 9'h010, 0, 32'hDEAD80EF, 0, 0);

    xact("sw20", 1, 3'b010, 9'h020, 32'h11223344, 0, 0, 0);
    xact("sh22", 1, 3'b001, 9'h022, 32'h0000ABCD, 0, 0, 0);
    xact("lh22", 0, 3'b001, 9'h022, 0, 32'hFFFFABCD, 0, 0);
    xact("lhu22", 0, 3'b101, 9'h022, 0, 32'h0000ABCD, 0, 0);
    xact("lw20", 0, 3'b010, 9'h020, 0, 32'hABCD3344, 0, 0);

    xact("sw40", 1, 3'b010, 9'h040, 32'h55, 0, 0, 0);
    xact("bp", 0, 3'b010, 9'h010, 0, 32'hDEAD80EF, 0, 5);
    xact("lw40", 0, 3'b010, 9'h040, 0, 32'h00000055, 0, 0);

    xact("sw30z", 1, 3'b010, 9'h030, 32'h0, 0, 0, 0);
    wait_ready("abort");
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 9'h030;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_v", 32'(rsp_valid), 32'd0);
    check("abort_rr", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    xact("lw30z", 0, 3'b010, 9'h030, 0, 32'h0, 0, 0);

    xact("sw30", 1, 3'b010, 9'h030, 32'hCAFEF00D, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
    xact("lw31", 0, 3'b010, 9'h031, 0, 32'h0, 1, 0);
`else
    xact("lw31", 0, 3'b010, 9'h031, 0, 32'hCAFEF00D, 0, 0);
`endif
    xact("ld011", 0, 3'b011, 9'h030, 0, 32'h0, 1, 0);
    xact("st011", 1, 3'b011, 9'h030, 32'h1, 0, 1, 0);
    xact("lw30", 0, 3'b010, 9'h030, 0, 32'hCAFEF00D, 0, 0);
    xact("lbu33", 0, 3'b100, 9'h033, 0, 32'h000000CA, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
